// File: rtl/sharpe_frame_parser_if.sv
// rtl/sharpe_frame_parser_if.sv - RX FIFO, pair handshake and status bundle for the Sharpe frame parser
interface sharpe_frame_parser_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic [7:0] sharpe_old;
    logic [7:0] sharpe_new;
    logic       pair_valid;
    logic       pair_ready;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    // Parser side: pops the FIFO and sources the pair and status.
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  pair_ready,
        output fifo_rd_en,
        output sharpe_old,
        output sharpe_new,
        output pair_valid,
        output frame_err,
        output err_cnt,
        output busy
    );

    // FIFO / comparator side.
    modport slave (
        output fifo_empty,
        output fifo_dout,
        output pair_ready,
        input  fifo_rd_en,
        input  sharpe_old,
        input  sharpe_new,
        input  pair_valid,
        input  frame_err,
        input  err_cnt,
        input  busy
    );
endinterface

// File: rtl/sharpe_frame_parser.sv
// rtl/sharpe_frame_parser.sv - parses HDR/old/new/checksum frames from the UART RX FIFO into a valid/ready pair
module sharpe_frame_parser #(
    parameter logic [7:0] HDR_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sharpe_frame_parser_if.master  bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_OLD,
        S_NEW,
        S_CSUM,
        S_OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rd_pending;
    logic             byte_vld;
    logic             rd_en;
    logic [7:0]       old_tmp;
    logic [7:0]       new_tmp;
    logic [7:0]       csum_calc;
    logic             csum_ok;
    logic             csum_bad;
    logic             timeout;
    logic             cnt_inc;
    logic [CNT_W-1:0] to_cnt;
    logic [7:0]       sharpe_old_r;
    logic [7:0]       sharpe_new_r;
    logic             pair_valid_r;
    logic             frame_err_r;
    logic [7:0]       err_cnt_r;

    // The FIFO presents data one cycle after the pop, so a byte is valid exactly when a read is pending.
    assign byte_vld  = rd_pending;
    assign csum_calc = HDR_BYTE + old_tmp + new_tmp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        csum_ok   = 1'b0;
        csum_bad  = 1'b0;
        timeout   = 1'b0;
        cnt_inc   = 1'b0;

        if (rst_n && state != S_OUT && !bus.fifo_empty && !rd_pending) begin
            rd_en = 1'b1;
        end

        unique case (state)
            S_HDR: begin
                if (byte_vld && bus.fifo_dout == HDR_BYTE) begin
                    state_nxt = S_OLD;
                end
            end
            S_OLD, S_NEW, S_CSUM: begin
                if (byte_vld) begin
                    if (state == S_OLD) begin
                        state_nxt = S_NEW;
                    end else if (state == S_NEW) begin
                        state_nxt = S_CSUM;
                    end else if (bus.fifo_dout == csum_calc) begin
                        csum_ok   = 1'b1;
                        state_nxt = S_OUT;
                    end else begin
                        csum_bad  = 1'b1;
                        state_nxt = S_HDR;
                    end
                end else if (to_cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_HDR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_OUT: begin
                if (pair_valid_r && bus.pair_ready) begin
                    state_nxt = S_HDR;
                end
            end
            default: begin
                state_nxt = S_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pending   <= 1'b0;
            old_tmp      <= 8'h00;
            new_tmp      <= 8'h00;
            to_cnt       <= '0;
            sharpe_old_r <= 8'h00;
            sharpe_new_r <= 8'h00;
            pair_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            err_cnt_r    <= 8'h00;
        end else begin
            rd_pending <= rd_en;

            if (byte_vld && state == S_OLD) begin
                old_tmp <= bus.fifo_dout;
            end
            if (byte_vld && state == S_NEW) begin
                new_tmp <= bus.fifo_dout;
            end

            to_cnt <= cnt_inc ? to_cnt + CNT_W'(1) : '0;

            // Published pair only changes on a clean checksum; it stays put through backpressure.
            if (csum_ok) begin
                sharpe_old_r <= old_tmp;
                sharpe_new_r <= new_tmp;
            end

            if (csum_ok) begin
                pair_valid_r <= 1'b1;
            end else if (pair_valid_r && bus.pair_ready) begin
                pair_valid_r <= 1'b0;
            end

            frame_err_r <= csum_bad | timeout;
            if ((csum_bad | timeout) && err_cnt_r != 8'hFF) begin
                err_cnt_r <= err_cnt_r + 8'h01;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.sharpe_old = sharpe_old_r;
    assign bus.sharpe_new = sharpe_new_r;
    assign bus.pair_valid = pair_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.err_cnt    = err_cnt_r;
    assign bus.busy       = (state != S_HDR);
endmodule

// File: tb/tb_sharpe_frame_parser.sv
// tb/tb_sharpe_frame_parser.sv - directed bench for sharpe_frame_parser with a frame-level reference model
module tb_sharpe_frame_parser;
    localparam int         TO  = 16;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sharpe_frame_parser_if bus ();

    sharpe_frame_parser #(
        .HDR_BYTE       (HDR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // FIFO storage: main process owns wr_ptr, FIFO process owns rd_ptr.
    logic [7:0] fifo_mem [0:2047];
    int wr_ptr = 0;
    int rd_ptr = 0;

    // Frame model state, written only by the FIFO process.
    logic [7:0]  frm [$];
    logic [15:0] exp_pairs [$];
    int csum_errs = 0;
    int pops = 0;
    int last_pop_cyc = 0;

    // Requests from the main process to the model.
    int reset_gen = 0;
    int aborts = 0;

    // Observations, written only by the compare process.
    int err_pulses = 0;
    int pulses_since_reset = 0;
    int last_err_cyc = 0;
    int pv_cycles = 0;
    int pairs_seen = 0;
    logic       prev_pv = 1'b0;
    logic       prev_xfer = 1'b0;
    logic [7:0] prev_old = 8'h00;
    logic [7:0] prev_new = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sat255(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Frame rule: wait for HDR, take three more bytes, accept when HDR+old+new == csum mod 256.
    function automatic void model_byte(input logic [7:0] b);
        int s;
        if (frm.size() == 0 && b != HDR) return;
        frm.push_back(b);
        if (frm.size() == 4) begin
            s = (int'(frm[0]) + int'(frm[1]) + int'(frm[2])) % 256;
            if (s == int'(frm[3])) exp_pairs.push_back({frm[1], frm[2]});
            else csum_errs++;
            frm.delete();
        end
    endfunction

    initial begin : fifo_proc
        logic pop;
        logic [7:0] b;
        int seen_reset;
        int seen_abort;
        seen_reset = 0;
        seen_abort = 0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = 8'h00;
        forever begin
            @(negedge clk);
            pop = bus.fifo_rd_en;
            @(posedge clk);
            #1;
            if (seen_reset != reset_gen || seen_abort != aborts) begin
                frm.delete();
                seen_reset = reset_gen;
                seen_abort = aborts;
            end
            if (pop && rd_ptr != wr_ptr) begin
                b = fifo_mem[rd_ptr];
                rd_ptr++;
                bus.fifo_dout = b;
                model_byte(b);
                pops++;
                last_pop_cyc = cyc;
            end
            bus.fifo_empty = (rd_ptr == wr_ptr);
        end
    end

    initial begin : compare_proc
        logic xfer;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pulses_since_reset = 0;
                prev_pv = 1'b0;
                prev_xfer = 1'b0;
            end else begin
                check("rd_en_while_empty", 32'(bus.fifo_rd_en && bus.fifo_empty), 32'd0);
                check("rd_en_while_pair_valid", 32'(bus.fifo_rd_en && bus.pair_valid), 32'd0);
                if (bus.frame_err) begin
                    err_pulses++;
                    pulses_since_reset++;
                    last_err_cyc = cyc;
                    check("frame_err_expected", 32'(err_pulses <= csum_errs + aborts), 32'd1);
                    check("err_cnt_on_pulse", 32'(bus.err_cnt), 32'(sat255(pulses_since_reset)));
                end
                if (bus.pair_valid) begin
                    pv_cycles++;
                    if (prev_pv && !prev_xfer) begin
                        check("pair_old_stable", 32'(bus.sharpe_old), 32'(prev_old));
                        check("pair_new_stable", 32'(bus.sharpe_new), 32'(prev_new));
                    end
                end
                xfer = bus.pair_valid && bus.pair_ready;
                if (xfer) begin
                    if (pairs_seen < exp_pairs.size()) begin
                        check("pair_old", 32'(bus.sharpe_old), 32'(exp_pairs[pairs_seen][15:8]));
                        check("pair_new", 32'(bus.sharpe_new), 32'(exp_pairs[pairs_seen][7:0]));
                    end else begin
                        check("unexpected_pair", 32'd1, 32'd0);
                    end
                    pairs_seen++;
                end
                prev_pv = bus.pair_valid;
                prev_xfer = xfer;
                prev_old = bus.sharpe_old;
                prev_new = bus.sharpe_new;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic drain(input int extra);
        int n;
        n = 0;
        while (rd_ptr != wr_ptr && n < 5000) begin
            tick(1);
            n++;
        end
        check("drain_bound", 32'(rd_ptr == wr_ptr), 32'd1);
        tick(extra);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        reset_gen++;
    endtask

    initial begin : main_proc
        int ps0;
        int pv0;
        int ep0;
        int pops0;
        int n;
        bus.pair_ready = 1'b1;
        tick(3);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_pair_valid", 32'(bus.pair_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_sharpe_old", 32'(bus.sharpe_old), 32'd0);
        check("rst_sharpe_new", 32'(bus.sharpe_new), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Clean frame.
        ps0 = pairs_seen; pv0 = pv_cycles; ep0 = err_pulses;
        push(8'hA5); push(8'h40); push(8'h3C); push(8'h21);
        drain(6);
        check("t1_pairs", 32'(pairs_seen - ps0), 32'd1);
        check("t1_pv_cycles", 32'(pv_cycles - pv0), 32'd1);
        check("t1_sharpe_old", 32'(bus.sharpe_old), 32'h40);
        check("t1_sharpe_new", 32'(bus.sharpe_new), 32'h3C);
        check("t1_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("t1_err_pulses", 32'(err_pulses - ep0), 32'd0);

        // Junk then bad checksum.
        do_reset();
        ps0 = pairs_seen; ep0 = err_pulses;
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h40); push(8'h3C); push(8'h22);
        drain(6);
        check("t2_err_pulses", 32'(err_pulses - ep0), 32'd1);
        check("t2_err_cnt", 32'(bus.err_cnt), 32'd1);
        check("t2_pairs", 32'(pairs_seen - ps0), 32'd0);
        check("t2_sharpe_old", 32'(bus.sharpe_old), 32'd0);
        check("t2_sharpe_new", 32'(bus.sharpe_new), 32'd0);

        // Backpressure stall.
        do_reset();
        bus.pair_ready = 1'b0;
        ps0 = pairs_seen;
        push(8'h13); push(8'hA5); push(8'h7B); push(8'h7B); push(8'h9B);
        push(8'hA5); push(8'h40); push(8'h3C); push(8'h21);
        n = 0;
        while (!bus.pair_valid && n < 200) begin
            tick(1);
            n++;
        end
        check("t3_pair_valid_seen", 32'(bus.pair_valid), 32'd1);
        pops0 = pops;
        tick(20);
        check("t3_no_pops_in_stall", 32'(pops - pops0), 32'd0);
        check("t3_held_valid", 32'(bus.pair_valid), 32'd1);
        check("t3_held_old", 32'(bus.sharpe_old), 32'h7B);
        check("t3_held_new", 32'(bus.sharpe_new), 32'h7B);
        bus.pair_ready = 1'b1;
        drain(8);
        check("t3_pairs", 32'(pairs_seen - ps0), 32'd2);
        check("t3_last_old", 32'(bus.sharpe_old), 32'h40);
        check("t3_last_new", 32'(bus.sharpe_new), 32'h3C);

        // Inter-byte timeout.
        do_reset();
        ep0 = err_pulses;
        push(8'hA5); push(8'h40);
        drain(0);
        aborts++;
        n = 0;
        while (err_pulses == ep0 && n < 60) begin
            tick(1);
            n++;
        end
        check("t4_err_pulses", 32'(err_pulses - ep0), 32'd1);
        check("t4_timeout_latency", 32'(last_err_cyc - last_pop_cyc), 32'd17);
        check("t4_busy_after", 32'(bus.busy), 32'd0);
        check("t4_err_cnt", 32'(bus.err_cnt), 32'd1);
        ps0 = pairs_seen;
        push(8'hA5); push(8'h7B); push(8'h7B); push(8'h9B);
        drain(6);
        check("t4_pairs", 32'(pairs_seen - ps0), 32'd1);
        check("t4_sharpe_old", 32'(bus.sharpe_old), 32'h7B);
        check("t4_sharpe_new", 32'(bus.sharpe_new), 32'h7B);

        // Reset mid-frame.
        do_reset();
        push(8'hA5); push(8'h40); push(8'h3C);
        drain(2);
        do_reset();
        ps0 = pairs_seen; ep0 = err_pulses;
        push(8'hA5); push(8'h7B); push(8'h7B); push(8'h9B);
        drain(6);
        check("t5_pairs", 32'(pairs_seen - ps0), 32'd1);
        check("t5_err_pulses", 32'(err_pulses - ep0), 32'd0);
        check("t5_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("t5_sharpe_old", 32'(bus.sharpe_old), 32'h7B);
        check("t5_sharpe_new", 32'(bus.sharpe_new), 32'h7B);

        // err_cnt saturation.
        do_reset();
        ep0 = err_pulses;
        for (int i = 0; i < 300; i++) begin
            push(8'hA5); push(8'h00); push(8'h00); push(8'h00);
        end
        drain(8);
        check("t6_err_pulses", 32'(err_pulses - ep0), 32'd300);
        check("t6_err_cnt", 32'(bus.err_cnt), 32'hFF);

        check("end_err_total", 32'(err_pulses), 32'(csum_errs + aborts));
        check("end_pair_total", 32'(pairs_seen), 32'(exp_pairs.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
